// File: rtl/instr_decode_stage.sv
// RV32 decode stage: each accepted word is decoded at push time and stored in a
// 2-entry FIFO. The head entry is held in dedicated registers so every output
// comes straight from a flop. Saturating counters track pops and illegal pops.
module instr_decode_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [2:0]       funct3,
  output logic [11:0]      imm,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [1:0]       cls,
  output logic             sra,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  cls;
    logic        sra;
    logic        ill;
  } entry_t;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  state_e           state_q, state_d;
  logic             live_q;
  entry_t           mem_q [2];
  entry_t           head_q, head_d, dec_e;
  logic             wr_ptr_q, rd_ptr_q;
  logic             push, pop;
  logic [CNT_W-1:0] dec_cnt_q, ill_cnt_q;
  logic [6:0]       opcode, funct7;
  logic [2:0]       f3;

  // Decode the incoming word into a FIFO entry
  always_comb begin
    opcode    = instr[6:0];
    funct7    = instr[31:25];
    f3        = instr[14:12];
    dec_e     = '0;
    dec_e.pc  = pc;
    dec_e.f3  = f3;
    dec_e.imm = instr[31:20];
    dec_e.rd  = instr[11:7];
    dec_e.rs1 = instr[19:15];
    dec_e.rs2 = instr[24:20];
    case (opcode)
      OPC_OPIMM: begin
        dec_e.cls = 2'd0;
        if (f3 == 3'b001)      dec_e.ill = (funct7 != 7'b0);
        else if (f3 == 3'b101) dec_e.ill = !((funct7 == 7'b0) || (funct7 == F7_ALT));
        else                   dec_e.ill = 1'b0;
      end
      OPC_OP: begin
        dec_e.cls = 2'd1;
        dec_e.ill = !((funct7 == 7'b0) ||
                      ((funct7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_LOAD: begin
        dec_e.cls = 2'd2;
        dec_e.ill = (f3 inside {3'b011, 3'b110, 3'b111});
      end
      default: begin
        dec_e.cls = 2'd3;
        dec_e.ill = 1'b1;
      end
    endcase
    dec_e.sra = ((f3 == 3'b101) && (dec_e.cls[1] == 1'b0)) ? instr[30] : 1'b0;
  end

  // FIFO occupancy state register; live_q keeps in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next occupancy from push/pop, flush overrides both
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE:     if (push && !pop) state_d = FULL;
                 else if (!push && pop) state_d = EMPTY;
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs derived from occupancy only
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = live_q && (state_q != FULL);
  end

  // Transfer qualification; flush cancels both transfers
  always_comb begin
    push = in_valid && in_ready && !flush;
    pop  = out_valid && out_ready && !flush;
  end

  // Next head: the new word when it lands in an empty (or draining single) FIFO,
  // the second slot when FULL pops; otherwise the last head is held
  always_comb begin
    head_d = head_q;
    if (push && ((state_q == EMPTY) || pop)) head_d = dec_e;
    else if (pop && (state_q == FULL))       head_d = mem_q[~rd_ptr_q];
  end

  // Storage, pointers and head register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      head_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      head_q <= head_d;
      if (push) begin
        mem_q[wr_ptr_q] <= dec_e;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Saturating statistics counters, advanced on pops only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
      ill_cnt_q <= '0;
    end else if (pop) begin
      if (dec_cnt_q != '1)               dec_cnt_q <= dec_cnt_q + CNT_W'(1);
      if (head_q.ill && ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + CNT_W'(1);
    end
  end

  // Head fields straight from the head register
  always_comb begin
    out_pc    = head_q.pc;
    funct3    = head_q.f3;
    imm       = head_q.imm;
    rd        = head_q.rd;
    rs1       = head_q.rs1;
    rs2       = head_q.rs2;
    cls       = head_q.cls;
    sra       = head_q.sra;
    illegal   = head_q.ill;
    dec_count = dec_cnt_q;
    ill_count = ill_cnt_q;
  end

endmodule
